// File: rtl/bc_game_controller.sv
// bc_game_controller: Bulls & Cows sequencer (LFSR secret, guess entry, scoring).
// Define BC_SHOW_SECRET_EN to expose the secret outside WON/LOST (debug build).
module bc_game_controller #(
    parameter int          MAX_TRIES = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       digit_valid,
    input  logic [3:0] digit_in,
    input  logic       clear,
    output logic [3:0] secret_number_0,
    output logic [3:0] secret_number_1,
    output logic [3:0] secret_number_2,
    output logic [3:0] secret_number_3,
    output logic [3:0] guessed_number_0,
    output logic [3:0] guessed_number_1,
    output logic [3:0] guessed_number_2,
    output logic [3:0] guessed_number_3,
    output logic [2:0] bulls,
    output logic [2:0] cows,
    output logic [3:0] tries,
    output logic       guess_ready,
    output logic       dup_err,
    output logic       game_won,
    output logic       game_lost
);
    typedef enum logic [2:0] {IDLE, GEN, ENTRY, SCORE, WON, LOST} state_t;

    localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [3:0]  TRIES_MAX = 4'(MAX_TRIES);

    state_t          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [3:0][3:0] secret_q, secret_d;
    logic [3:0][3:0] guess_q, guess_d;
    logic [1:0]      idx_q, idx_d;
    logic [2:0]      bulls_q, bulls_d;
    logic [2:0]      cows_q, cows_d;
    logic [3:0]      tries_q, tries_d;
    logic            dup_q, dup_d;

    logic [3:0] cand;
    logic       cand_seen;
    logic       digit_seen;
    logic [2:0] bull_cnt;
    logic [2:0] cow_cnt;
    logic       show;

    assign cand = lfsr_q[3:0];

    // Duplicate checks only look at slots already typed in the current guess.
    always_comb begin
        cand_seen  = 1'b0;
        digit_seen = 1'b0;
        bull_cnt   = '0;
        cow_cnt    = '0;
        for (int i = 0; i < 4; i++) begin
            cand_seen  |= secret_q[i] == cand;
            digit_seen |= (2'(i) < idx_q) && (guess_q[i] == digit_in);
            bull_cnt   += 3'(guess_q[i] == secret_q[i]);
            for (int j = 0; j < 4; j++) begin
                cow_cnt += 3'((i != j) && (guess_q[i] == secret_q[j]));
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        secret_d = secret_q;
        guess_d  = guess_q;
        idx_d    = idx_q;
        bulls_d  = bulls_q;
        cows_d   = cows_q;
        tries_d  = tries_q;
        dup_d    = 1'b0;
        case (state_q)
            IDLE, WON, LOST: begin
                if (start) begin
                    state_d  = GEN;
                    secret_d = {4{4'hF}};
                    guess_d  = {4{4'hF}};
                    idx_d    = '0;
                    bulls_d  = '0;
                    cows_d   = '0;
                    tries_d  = '0;
                end
            end
            GEN: begin
                if (cand < 4'd10 && !cand_seen) begin
                    secret_d[idx_q] = cand;
                    idx_d           = idx_q + 2'd1;
                    state_d         = (idx_q == 2'd3) ? ENTRY : GEN;
                end
            end
            ENTRY: begin
                if (clear) begin
                    idx_d   = '0;
                    guess_d = {4{4'hF}};
                end else if (digit_valid && digit_in < 4'd10) begin
                    if (digit_seen) begin
                        dup_d = 1'b1;
                    end else begin
                        // The previous guess stays on the panel until the first new digit lands.
                        guess_d         = (idx_q == 2'd0) ? {4{4'hF}} : guess_q;
                        guess_d[idx_q]  = digit_in;
                        idx_d           = idx_q + 2'd1;
                        state_d         = (idx_q == 2'd3) ? SCORE : ENTRY;
                    end
                end
            end
            SCORE: begin
                bulls_d = bull_cnt;
                cows_d  = cow_cnt;
                tries_d = tries_q + 4'd1;
                idx_d   = '0;
                state_d = (bull_cnt == 3'd4) ? WON :
                          (tries_q + 4'd1 == TRIES_MAX) ? LOST : ENTRY;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            secret_q <= {4{4'hF}};
            guess_q  <= {4{4'hF}};
            idx_q    <= '0;
            bulls_q  <= '0;
            cows_q   <= '0;
            tries_q  <= '0;
            dup_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            secret_q <= secret_d;
            guess_q  <= guess_d;
            idx_q    <= idx_d;
            bulls_q  <= bulls_d;
            cows_q   <= cows_d;
            tries_q  <= tries_d;
            dup_q    <= dup_d;
        end
    end

`ifdef BC_SHOW_SECRET_EN
    assign show = 1'b1;
`else
    assign show = (state_q == WON) || (state_q == LOST);
`endif

    assign secret_number_0  = show ? secret_q[0] : 4'hF;
    assign secret_number_1  = show ? secret_q[1] : 4'hF;
    assign secret_number_2  = show ? secret_q[2] : 4'hF;
    assign secret_number_3  = show ? secret_q[3] : 4'hF;
    assign guessed_number_0 = guess_q[0];
    assign guessed_number_1 = guess_q[1];
    assign guessed_number_2 = guess_q[2];
    assign guessed_number_3 = guess_q[3];
    assign bulls            = bulls_q;
    assign cows             = cows_q;
    assign tries            = tries_q;
    assign dup_err          = dup_q;
    assign guess_ready      = state_q == ENTRY;
    assign game_won         = state_q == WON;
    assign game_lost        = state_q == LOST;
endmodule
